// File: rtl/inst_fetch_assembler.sv
// Byte-serial instruction fetch: walks four byte addresses, assembles a little-endian
// 32-bit instruction and offers it to the decoder. Optional macro: IFETCH_PERF_CNT_EN.
module inst_fetch_assembler #(
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned MEM_BYTES = 32
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_data,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        busy
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   localparam logic [31:0] ADDR_MASK  = 32'(MEM_BYTES - 1);
   localparam logic [31:0] RESET_ADDR = 32'(RESET_PC) & ADDR_MASK;

   typedef enum logic [1:0] {
      S_ADDR,
      S_LAST,
      S_HOLD
   } state_e;

   state_e      state_q;
   logic [1:0]  idx_q;
   logic [31:0] pc_q;
   logic [7:0]  buf0_q;
   logic [7:0]  buf1_q;
   logic [7:0]  buf2_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        valid_q;
   logic        busy_q;
   logic [31:0] mem_addr_q;

   logic [1:0]  idx_d;
   logic [31:0] addr_d;
   logic [31:0] pc_plus4_d;
   logic [31:0] redirect_target_d;
   logic        transfer;

   // The address stops advancing at pc+3 so it stays there through S_LAST and S_HOLD.
   assign idx_d             = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
   assign addr_d            = (pc_q + {30'b0, idx_d}) & ADDR_MASK;
   assign pc_plus4_d        = (pc_q + 32'd4) & ADDR_MASK;
   assign redirect_target_d = redirect_pc & ~32'h3 & ADDR_MASK;
   assign transfer          = valid_q && instr_ready;

   // Redirect outranks everything, including a handshake in S_HOLD.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_ADDR;
         idx_q      <= 2'd0;
         pc_q       <= RESET_ADDR;
         buf0_q     <= 8'd0;
         buf1_q     <= 8'd0;
         buf2_q     <= 8'd0;
         instr_q    <= 32'd0;
         instr_pc_q <= 32'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b1;
         mem_addr_q <= RESET_ADDR;
      end else if (redirect_valid) begin
         state_q    <= S_ADDR;
         idx_q      <= 2'd0;
         pc_q       <= redirect_target_d;
         buf0_q     <= 8'd0;
         buf1_q     <= 8'd0;
         buf2_q     <= 8'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b1;
         mem_addr_q <= redirect_target_d;
      end else begin
         case (state_q)
            S_ADDR: begin
               case (idx_q)
                  2'd1:    buf0_q <= mem_data;
                  2'd2:    buf1_q <= mem_data;
                  2'd3:    buf2_q <= mem_data;
                  default: ;
               endcase
               if (idx_q == 2'd3) begin
                  state_q <= S_LAST;
               end else begin
                  idx_q <= idx_d;
               end
               mem_addr_q <= addr_d;
            end
            S_LAST: begin
               instr_q    <= {mem_data, buf2_q, buf1_q, buf0_q};
               instr_pc_q <= pc_q;
               state_q    <= S_HOLD;
               valid_q    <= 1'b1;
               busy_q     <= 1'b0;
            end
            S_HOLD: begin
               if (instr_ready) begin
                  pc_q       <= pc_plus4_d;
                  idx_q      <= 2'd0;
                  state_q    <= S_ADDR;
                  valid_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  mem_addr_q <= pc_plus4_d;
               end
            end
            default: begin
               state_q    <= S_ADDR;
               idx_q      <= 2'd0;
               valid_q    <= 1'b0;
               busy_q     <= 1'b1;
               mem_addr_q <= pc_q;
            end
         endcase
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q;

   // A handshake voided by a simultaneous redirect is not a completed fetch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_count_q <= 32'd0;
      end else if (transfer && !redirect_valid) begin
         fetch_count_q <= fetch_count_q + 32'd1;
      end
   end

   assign fetch_count = fetch_count_q;
`else
   logic unusedTransfer;
   assign unusedTransfer = transfer;
`endif

   assign mem_addr    = mem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_inst_fetch_assembler.sv
// Self-checking bench for inst_fetch_assembler: registered byte memory, a cycle-count
// reference model, directed scenarios and a randomized ready/redirect phase.
module tb_inst_fetch_assembler;

   logic        clock;
   logic        reset;
   logic [31:0] mem_addr;
   logic [7:0]  mem_data;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   logic [7:0] mem [32];

   int vectorsApplied;
   int miscompares;
   bit checkEn;

   int          mPc;
   int          mCnt;
   logic [31:0] mInstr;
   logic [31:0] mInstrPc;
   logic [31:0] mCount;

   inst_fetch_assembler #(
      .RESET_PC (0),
      .MEM_BYTES(32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .busy          (busy)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count)
`endif
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Registered instruction memory: the byte for an address sampled at an edge appears after it.
   always @(posedge clock) begin
      mem_data <= mem[mem_addr[4:0]];
   end

   // Reference model: a fetch is just a count of edges since it started at mPc.
   // Counts 0..3 put pc+count on the bus, count 4 holds pc+3, count 5 means the instruction is offered.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mPc      = 0;
         mCnt     = 0;
         mInstr   = 32'd0;
         mInstrPc = 32'd0;
         mCount   = 32'd0;
      end else if (redirect_valid) begin
         mPc  = int'(redirect_pc & 32'h1C);
         mCnt = 0;
      end else if (mCnt == 5) begin
         if (instr_ready) begin
            mPc    = (mPc + 4) % 32;
            mCnt   = 0;
            mCount = mCount + 32'd1;
         end
      end else begin
         if (mCnt == 4) begin
            mInstr   = {mem[(mPc + 3) % 32], mem[(mPc + 2) % 32], mem[(mPc + 1) % 32], mem[mPc]};
            mInstrPc = 32'(mPc);
         end
         mCnt = mCnt + 1;
      end
   end

   // One comparison of a named output against its required value.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, actual, expected);
      end
   endtask

   // Every falling edge, all outputs are held against the model.
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("cmp_valid", {31'd0, instr_valid}, {31'd0, mCnt == 5});
         checkOutput("cmp_busy", {31'd0, busy}, {31'd0, mCnt != 5});
         checkOutput("cmp_mem_addr", mem_addr, 32'((mPc + ((mCnt < 3) ? mCnt : 3)) % 32));
         checkOutput("cmp_instr", instr, mInstr);
         checkOutput("cmp_instr_pc", instr_pc, mInstrPc);
`ifdef IFETCH_PERF_CNT_EN
         checkOutput("cmp_fetch_count", fetch_count, mCount);
`endif
      end
   end

   // Drive this cycle's inputs, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clock);
      #1;
   endtask

   // Directed scenarios first, then a randomized run, then an asynchronous reset in S_LAST.
   initial begin
      vectorsApplied = 0;
      miscompares    = 0;
      checkEn        = 1'b0;
      mem_data       = 8'd0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      for (int i = 0; i < 32; i++) begin
         mem[i] = 8'($urandom);
      end
      mem[0]  = 8'h33; mem[1]  = 8'h8b; mem[2]  = 8'h20; mem[3]  = 8'h00;
      mem[4]  = 8'hb3; mem[5]  = 8'h8b; mem[6]  = 8'h41; mem[7]  = 8'h40;
      mem[16] = 8'h33; mem[17] = 8'h9d; mem[18] = 8'ha4; mem[19] = 8'h00;

      reset = 1'b1;
      #2 reset = 1'b0;
      #1 checkEn = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;

      checkOutput("rst_addr0", mem_addr, 32'd0);
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         checkOutput("first_addr", mem_addr, 32'(k));
      end
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("first_not_yet_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("first_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("first_instr", instr, 32'h00208b33);
      checkOutput("first_pc", instr_pc, 32'd0);

      repeat (6) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("second_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("second_instr", instr, 32'h40418bb3);
      checkOutput("second_pc", instr_pc, 32'd4);
      repeat (42) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("wrap_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("wrap_pc", instr_pc, 32'd0);

      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("bp_valid", {31'd0, instr_valid}, 32'd1);
         checkOutput("bp_instr", instr, 32'h00208b33);
         checkOutput("bp_pc", instr_pc, 32'd0);
         checkOutput("bp_addr", mem_addr, 32'd3);
      end
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("bp_release_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("bp_release_addr", mem_addr, 32'd4);

      applyStimulus(1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("idx2_addr", mem_addr, 32'd6);
      applyStimulus(1'b1, 1'b1, 32'h11);
      checkOutput("redir_addr", mem_addr, 32'h10);
      checkOutput("redir_valid", {31'd0, instr_valid}, 32'd0);
      repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("redir_not_yet_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("redir_valid5", {31'd0, instr_valid}, 32'd1);
      checkOutput("redir_instr", instr, 32'h00a49d33);
      checkOutput("redir_pc", instr_pc, 32'h10);

      applyStimulus(1'b1, 1'b1, 32'h0000_0009);
      checkOutput("redir_xfer_addr", mem_addr, 32'd8);
      checkOutput("redir_xfer_valid", {31'd0, instr_valid}, 32'd0);

      for (int k = 0; k < 600; k++) begin
         applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), 32'($urandom));
      end

      applyStimulus(1'b1, 1'b1, 32'h14);
      repeat (4) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("last_addr", mem_addr, 32'h17);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("async_instr", instr, 32'd0);
      checkOutput("async_pc", instr_pc, 32'd0);
      checkOutput("async_addr", mem_addr, 32'd0);
      checkOutput("async_busy", {31'd0, busy}, 32'd1);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (5) applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("restart_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("restart_instr", instr, 32'h00208b33);
      checkOutput("restart_pc", instr_pc, 32'd0);

      applyStimulus(1'b1, 1'b0, 32'd0);
      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
